uart_rx_oversampled: RTL

//  Serial receiver; the far-end consumer of the UART transmitter's tx line.

---
 rtl/uart_rx_oversampled.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/uart_rx_oversampled.sv
// Oversampled UART receiver: 2-flop sync, 3-sample mid-bit vote,
// LSB-first frame reassembly with optional parity and stop check.
module uart_rx_oversampled #(
  parameter int oversampling_rate = 16,
  parameter int data_wd = 8,
  parameter int parity = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               rx,
  output logic [data_wd-1:0] dout,
  output logic               rx_done,
  output logic               rx_busy,
  output logic               parity_err,
  output logic               frame_err
);

  localparam int OSR = oversampling_rate;
  localparam int CW = $clog2(OSR);
  localparam int IW = (data_wd > 1) ? $clog2(data_wd) : 1;
  localparam logic [CW-1:0] V0 = CW'(OSR/2 - 1);
  localparam logic [CW-1:0] V1 = CW'(OSR/2);
  localparam logic [CW-1:0] V2 = CW'(OSR/2 + 1);
  localparam logic [CW-1:0] LAST = CW'(OSR - 1);
  localparam logic [IW-1:0] LAST_BIT = IW'(data_wd - 1);
  localparam bit PAR_EN = (parity == 1) || (parity == 2);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PAR, STOP
  } state_t;

  state_t state, state_nxt;

  logic               rx_m, rx_s, rx_p;
  logic [CW-1:0]      tick_cnt, cnt_nxt;
  logic [IW-1:0]      bit_idx;
  logic [data_wd-1:0] shreg;
  logic               s0, s1, par_bit;
  logic               fall, vote, at_vote, at_last;
  logic               last_bit, par_exp;

  // Decisions use the count value this tick advances to.
  assign cnt_nxt  = tick_cnt + CW'(1);
  assign fall     = rx_p & ~rx_s;
  assign at_vote  = tick && (cnt_nxt == V2);
  assign at_last  = tick && (cnt_nxt == LAST);
  assign vote     = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
  assign last_bit = (bit_idx == LAST_BIT);
  assign rx_busy  = (state != IDLE);

  always_comb begin
    par_exp = 1'b0;
    if (parity == 1) par_exp = ^shreg;
    else par_exp = ~^shreg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_p <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_p <= rx_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (state == IDLE && fall) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s0 <= 1'b1;
      s1 <= 1'b1;
    end else if (tick) begin
      if (cnt_nxt == V0) s0 <= rx_s;
      if (cnt_nxt == V1) s1 <= rx_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (fall) state_nxt = START;
      START: begin
        if (at_vote && vote) state_nxt = IDLE;
        else if (at_last) state_nxt = DATA;
      end
      DATA: begin
        if (at_last && last_bit)
          state_nxt = PAR_EN ? PAR : STOP;
      end
      PAR:   if (at_last) state_nxt = STOP;
      STOP:  if (at_vote) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_idx    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      dout       <= '0;
      rx_done    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      if (state == START && at_last)
        bit_idx <= '0;
      if (state == DATA && at_vote)
        shreg[bit_idx] <= vote;
      if (state == DATA && at_last && !last_bit)
        bit_idx <= bit_idx + IW'(1);
      if (state == PAR && at_vote)
        par_bit <= vote;
      if (state == STOP && at_vote) begin
        dout       <= shreg;
        frame_err  <= ~vote;
        parity_err <= PAR_EN && (par_bit != par_exp);
        rx_done    <= 1'b1;
      end
    end
  end

endmodule
